// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU front-end types: word/address widths, fetch FSM states and the queue entry layout.
package cpu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fq_entry_t;

    // Sequential fetch address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-unit bus: instruction-memory read channel plus the decode-facing head of the queue.
interface instr_fetch_queue_if;
    import cpu_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_data;
    logic              inst_valid;
    logic [WORD_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_data, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_data, inst_ready
    );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Prefetch queue storage: DEPTH entries of {instruction, pc} with single-edge flush.
module fq_fifo
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fq_entry_t        din,
    output logic [CNT_W-1:0] count,
    output fq_entry_t        head
);

    fq_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: one-outstanding-read fetch FSM feeding a prefetch queue.
// Optional FETCH_PERF_EN macro enables the saturating fetch-starvation counter bubble_cnt.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    instr_fetch_queue_if.master  bus,
    output logic [15:0]          bubble_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q;

    logic              imem_req_c;
    logic [ADDR_W-1:0] imem_addr_c;
    logic              push_c;
    logic              pop_c;
    logic              inst_valid_c;
    logic              has_space_c;
    logic [CNT_W-1:0]  fifo_count;
    fq_entry_t         fifo_head;
    fq_entry_t         fifo_din;

    assign has_space_c  = fifo_count < CNT_W'(DEPTH);
    assign inst_valid_c = fifo_count != '0;
    assign pop_c        = inst_valid_c && bus.inst_ready && !redirect;

    // In WAIT/DRAIN the address comes from the captured request, since fetch_pc may be redirected.
    assign imem_addr_c = (state_q == FETCH) ? fetch_pc_q : req_addr_q;

    always_comb begin
        imem_req_c = 1'b0;
        case (state_q)
            FETCH:       imem_req_c = has_space_c && !redirect;
            WAIT, DRAIN: imem_req_c = 1'b1;
            default:     imem_req_c = 1'b0;
        endcase
        if (RST) imem_req_c = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_c     = 1'b0;
        if (redirect) begin
            // Redirect wins; an un-acked read must still complete before the next issue.
            fetch_pc_d = redirect_pc;
            if (state_q != FETCH && !bus.imem_ack) state_d = DRAIN;
            else                                   state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_req_c) begin
                        if (bus.imem_ack) begin
                            push_c     = 1'b1;
                            fetch_pc_d = pc_inc(imem_addr_c);
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        push_c     = 1'b1;
                        fetch_pc_d = pc_inc(imem_addr_c);
                        state_d    = FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
        if (RST) push_c = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST)                   req_addr_q <= RESET_PC;
        else if (state_q == FETCH) req_addr_q <= fetch_pc_q;
    end

    assign fifo_din = '{instr: bus.imem_data, pc: imem_addr_c};

    fq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push_c),
        .pop   (pop_c),
        .flush (redirect),
        .din   (fifo_din),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign bus.imem_req   = imem_req_c;
    assign bus.imem_addr  = imem_addr_c;
    assign bus.inst_valid = inst_valid_c;
    assign bus.inst       = fifo_head.instr;
    assign bus.inst_pc    = fifo_head.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] bubble_q;

    // Cycles where decode is ready but the queue has nothing for it.
    always_ff @(posedge CLK) begin
        if (RST)
            bubble_q <= '0;
        else if (bus.inst_ready && !inst_valid_c && bubble_q != 16'hFFFF)
            bubble_q <= bubble_q + 16'(1);
    end

    assign bubble_cnt = bubble_q;
`else
    assign bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; memory returns addr ^ 16'hA5A5 as the instruction word.
module tb_instr_fetch_queue;
    import cpu_pkg::*;

`ifdef FETCH_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [15:0]       bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_queue_if bus();

    assign bus.imem_data = bus.imem_addr ^ 16'hA5A5;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b0;
        cyc();
        @(negedge CLK);
        chk("rst_valid",  32'(bus.inst_valid), 32'd0);
        chk("rst_req",    32'(bus.imem_req),   32'd0);
        chk("rst_bubble", 32'(bubble_cnt),     32'd0);
        cyc();
        RST = 1'b0;
    endtask

    initial begin
        // Streaming: ack always, decode always ready.
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        @(negedge CLK);
        chk("c1_req",   32'(bus.imem_req),   32'd1);
        chk("c1_addr",  32'(bus.imem_addr),  32'h0000);
        chk("c1_valid", 32'(bus.inst_valid), 32'd0);
        cyc();
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk($sformatf("stream_valid%0d", i), 32'(bus.inst_valid), 32'd1);
            chk($sformatf("stream_pc%0d", i),    32'(bus.inst_pc),    32'(i));
            chk($sformatf("stream_inst%0d", i),  32'(bus.inst),       32'(16'(i) ^ 16'hA5A5));
            cyc();
        end

        // Back-pressure: queue fills to 4, then drains in order with memory stalled.
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (10) cyc();
        @(negedge CLK);
        chk("full_req",   32'(bus.imem_req),   32'd0);
        chk("full_valid", 32'(bus.inst_valid), 32'd1);
        chk("full_pc",    32'(bus.inst_pc),    32'h0000);
        cyc();
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("drain_valid%0d", i), 32'(bus.inst_valid), 32'd1);
            chk($sformatf("drain_pc%0d", i),    32'(bus.inst_pc),    32'(i));
            cyc();
        end
        @(negedge CLK);
        chk("empty_valid", 32'(bus.inst_valid), 32'd0);
        chk("empty_req",   32'(bus.imem_req),   32'd1);
        chk("empty_addr",  32'(bus.imem_addr),  32'h0004);

        // Redirect during an un-acked read at 0x0005 -> drain, then fetch 0x0040.
        do_reset();
        bus.inst_ready = 1'b1;
        redirect       = 1'b1;
        redirect_pc    = 16'h0005;
        @(negedge CLK);
        chk("redir_gate_req", 32'(bus.imem_req), 32'd0);
        cyc();
        redirect = 1'b0;
        @(negedge CLK);
        chk("dly0_req",  32'(bus.imem_req),  32'd1);
        chk("dly0_addr", 32'(bus.imem_addr), 32'h0005);
        cyc();
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge CLK);
        chk("dly1_addr", 32'(bus.imem_addr), 32'h0005);
        cyc();
        redirect = 1'b0;
        @(negedge CLK);
        chk("dly2_req",  32'(bus.imem_req),  32'd1);
        chk("dly2_addr", 32'(bus.imem_addr), 32'h0005);
        cyc();
        bus.imem_ack = 1'b1;
        @(negedge CLK);
        chk("dly3_addr", 32'(bus.imem_addr), 32'h0005);
        cyc();
        @(negedge CLK);
        chk("post_drain_addr",  32'(bus.imem_addr),  32'h0040);
        chk("post_drain_valid", 32'(bus.inst_valid), 32'd0);
        cyc();
        bus.imem_ack = 1'b0;
        @(negedge CLK);
        chk("tgt_valid", 32'(bus.inst_valid), 32'd1);
        chk("tgt_pc",    32'(bus.inst_pc),    32'h0040);
        chk("tgt_inst",  32'(bus.inst),       32'(16'h0040 ^ 16'hA5A5));

        // Three queued entries, redirect coinciding with a completing read.
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b0;
        repeat (3) cyc();
        bus.imem_ack = 1'b0;
        cyc();
        bus.imem_ack = 1'b1;
        redirect     = 1'b1;
        redirect_pc  = 16'h0100;
        @(negedge CLK);
        chk("q3_pc",   32'(bus.inst_pc),   32'h0000);
        chk("q3_addr", 32'(bus.imem_addr), 32'h0003);
        cyc();
        redirect       = 1'b0;
        bus.inst_ready = 1'b1;
        @(negedge CLK);
        chk("flush_valid", 32'(bus.inst_valid), 32'd0);
        chk("flush_addr",  32'(bus.imem_addr),  32'h0100);
        cyc();
        @(negedge CLK);
        chk("redir_pc0", 32'(bus.inst_pc), 32'h0100);
        cyc();
        @(negedge CLK);
        chk("redir_pc1", 32'(bus.inst_pc), 32'h0101);

        // Address wrap at the top of memory.
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        redirect       = 1'b1;
        redirect_pc    = 16'hFFFE;
        cyc();
        redirect = 1'b0;
        @(negedge CLK);
        chk("wrap_addr0", 32'(bus.imem_addr), 32'hFFFE);
        cyc();
        @(negedge CLK);
        chk("wrap_addr1", 32'(bus.imem_addr), 32'hFFFF);
        cyc();
        @(negedge CLK);
        chk("wrap_addr2", 32'(bus.imem_addr), 32'h0000);
        chk("wrap_pc1",   32'(bus.inst_pc),   32'hFFFF);
        cyc();
        @(negedge CLK);
        chk("wrap_pc2",   32'(bus.inst_pc),   32'h0000);

        // Starvation counter: one bubble before pc 0 arrives, then 20 starved cycles.
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        cyc();
        bus.imem_ack = 1'b0;
        @(negedge CLK);
        chk("bub_head_pc", 32'(bus.inst_pc), 32'h0000);
        cyc();
        @(negedge CLK);
        chk("bub_base", 32'(bubble_cnt), 32'(PERF * 1));
        repeat (20) cyc();
        @(negedge CLK);
        chk("bub_plus20", 32'(bubble_cnt), 32'(PERF * 21));
        bus.inst_ready = 1'b0;
        repeat (3) cyc();
        @(negedge CLK);
        chk("bub_hold", 32'(bubble_cnt), 32'(PERF * 21));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
